// File: rtl/shake256_padder.sv
// rtl/shake256_padder.sv - SHAKE256 byte-stream padder producing rate blocks for the KECCAK absorb core
module shake256_padder #(
  parameter int          RATE_WIDTH  = 1088,
  parameter logic [7:0]  DOMAIN_BYTE = 8'h1F,
  parameter int          IDX_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_keep,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  block_valid,
  output logic [RATE_WIDTH-1:0] block_data,
  output logic                  block_last,
  input  logic                  block_ready,
  output logic [IDX_WIDTH-1:0]  block_index
);

  localparam int RATE_BYTES = RATE_WIDTH / 8;
  localparam int CNT_W      = $clog2(RATE_BYTES + 1);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, PADBLK} state_t;

  state_t                state, next_state;
  logic [RATE_WIDTH-1:0] buffer, fill_buf, pad_blk;
  logic [CNT_W-1:0]      cnt, n_next;
  logic                  pad_pending, last_q;
  logic [IDX_WIDTH-1:0]  index_q, index_inc;
  logic                  accept, block_full;

  assign in_ready    = (state == FILL);
  assign block_valid = (state == EMIT) || (state == PADBLK);
  assign block_data  = buffer;
  assign block_last  = last_q;
  assign block_index = index_q;

  assign accept     = in_ready && in_valid;
  assign n_next     = cnt + CNT_W'(in_keep);
  assign block_full = in_keep && (cnt == CNT_W'(RATE_BYTES - 1));
  assign index_inc  = (index_q == '1) ? index_q : index_q + IDX_WIDTH'(1);

  // Bytes past cnt are always zero, so padding only has to place the domain byte and the 0x80 end marker.
  always_comb begin
    fill_buf = buffer;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (in_keep && i == int'(cnt)) fill_buf[8*i +: 8] = in_data;
    end
    if (in_last && !block_full) begin
      for (int i = 0; i < RATE_BYTES; i++) begin
        if (i == int'(n_next)) fill_buf[8*i +: 8] = DOMAIN_BYTE;
      end
      fill_buf[RATE_WIDTH-1 -: 8] = fill_buf[RATE_WIDTH-1 -: 8] | 8'h80;
    end
  end

  always_comb begin
    pad_blk                   = '0;
    pad_blk[7:0]              = DOMAIN_BYTE;
    pad_blk[RATE_WIDTH-1 -: 8] = 8'h80;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = FILL;
      FILL:    if (accept && (block_full || in_last)) next_state = EMIT;
      EMIT:    if (block_ready) next_state = pad_pending ? PADBLK : FILL;
      PADBLK:  if (block_ready) next_state = FILL;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer      <= '0;
      cnt         <= '0;
      pad_pending <= 1'b0;
      last_q      <= 1'b0;
      index_q     <= '0;
    end else begin
      case (state)
        FILL: if (accept) begin
          buffer <= fill_buf;
          cnt    <= n_next;
          if (block_full) begin
            last_q      <= 1'b0;
            pad_pending <= in_last;
          end else if (in_last) begin
            last_q <= 1'b1;
          end
        end
        EMIT: if (block_ready) begin
          cnt <= '0;
          // The pad-only block reuses the buffer so block_data stays a plain register.
          if (pad_pending) begin
            buffer  <= pad_blk;
            last_q  <= 1'b1;
            index_q <= index_inc;
          end else if (last_q) begin
            buffer  <= '0;
            last_q  <= 1'b0;
            index_q <= '0;
          end else begin
            buffer  <= '0;
            index_q <= index_inc;
          end
        end
        PADBLK: if (block_ready) begin
          buffer      <= '0;
          pad_pending <= 1'b0;
          last_q      <= 1'b0;
          index_q     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
